// File: rtl/bus_protocol_arbiter_pkg.sv
// Shared types, beat limits and the round-robin search used by the bus arbiter.
// The pick function works on a fixed MAX_REQ-wide vector so it can live outside any parameterised scope.
package bus_protocol_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam int unsigned MIN_BEATS = 2;
    localparam int unsigned MAX_BEATS = 4;
    localparam int unsigned MAX_REQ   = 8;

    typedef struct packed {
        logic [2:0]         idx;
        logic [MAX_REQ-1:0] onehot;
    } pick_t;

    // First requester at or after ptr, searching circularly over the n active lanes.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0]         ptr,
                                      input int unsigned        n);
        pick_t       p;
        int unsigned pos;
        logic        found;
        p     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = (32'(ptr) + k) % n;
            if (k < n && !found && req[pos]) begin
                found         = 1'b1;
                p.idx         = pos[2:0];
                p.onehot[pos] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/bus_protocol_arbiter_if.sv
// Requester-side and dValid/dAck/data bus signals of the arbiter, grouped for port passing.
// The arbiter connects through master; clients and the target side through slave.
interface bus_protocol_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic [N_REQ-1:0]    err;
    logic                dValid;
    logic                dAck;
    logic [DW-1:0]       data;
    logic                busy;

    modport master (
        input  req, req_data, dAck,
        output grant, done, err, dValid, data, busy
    );

    modport slave (
        output req, req_data, dAck,
        input  grant, done, err, dValid, data, busy
    );
endinterface

// File: rtl/bus_protocol_arbiter_rr.sv
// Combinational round-robin pick over N_REQ requesters with a registered priority pointer.
module rr_arbiter
    import bus_protocol_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_ptr_upd,
    input  logic [2:0]       i_ptr_next,
    output logic [N_REQ-1:0] o_grant,
    output logic [2:0]       o_idx,
    output logic             o_any
);
    logic [2:0]         r_ptr;
    logic [MAX_REQ-1:0] w_req_ext;
    pick_t              w_pick;

    assign w_req_ext = MAX_REQ'(i_req);
    assign w_pick    = rr_pick(w_req_ext, r_ptr, N_REQ);
    assign o_grant   = w_pick.onehot[N_REQ-1:0];
    assign o_idx     = w_pick.idx;
    assign o_any     = |w_pick.onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_ptr_upd) begin
            r_ptr <= i_ptr_next;
        end
    end
endmodule

// File: rtl/bus_protocol_arbiter.sv
// Round-robin master sequencer: latches the winner's data, holds dValid for 2..4 beats,
// and ends with done on a timely dAck or err on early ack / timeout.
module bus_protocol_arbiter
    import bus_protocol_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    bus_protocol_arbiter_if.master bus
);
    state_t           r_state, w_state_next;
    logic [N_REQ-1:0] r_grant, w_grant_next;
    logic [N_REQ-1:0] r_done,  w_done_next;
    logic [N_REQ-1:0] r_err,   w_err_next;
    logic [DW-1:0]    r_data,  w_data_next;
    logic [2:0]       r_beat,  w_beat_next;
    logic [2:0]       r_widx,  w_widx_next;

    logic [N_REQ-1:0] w_pick_grant;
    logic [2:0]       w_pick_idx;
    logic             w_pick_any;
    logic             w_ptr_upd;
    logic [2:0]       w_ptr_next;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk        (clk),
        .rst_n      (reset_n),
        .i_req      (bus.req),
        .i_ptr_upd  (w_ptr_upd),
        .i_ptr_next (w_ptr_next),
        .o_grant    (w_pick_grant),
        .o_idx      (w_pick_idx),
        .o_any      (w_pick_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_data  <= '0;
            r_beat  <= '0;
            r_widx  <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_data  <= w_data_next;
            r_beat  <= w_beat_next;
            r_widx  <= w_widx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_done_next  = '0;
        w_err_next   = '0;
        w_data_next  = r_data;
        w_beat_next  = r_beat;
        w_widx_next  = r_widx;
        w_ptr_upd    = 1'b0;
        w_ptr_next   = (r_widx == 3'(N_REQ - 1)) ? 3'd0 : r_widx + 3'd1;

        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_next = VALID;
                    w_grant_next = w_pick_grant;
                    w_data_next  = bus.req_data[32'(w_pick_idx) * DW +: DW];
                    w_beat_next  = 3'd1;
                    w_widx_next  = w_pick_idx;
                end
            end
            VALID: begin
                // Every exit path returns to IDLE, so dValid is always low for at least one cycle.
                if (bus.dAck || r_beat == 3'(MAX_BEATS)) begin
                    w_state_next = IDLE;
                    w_grant_next = '0;
                    w_beat_next  = '0;
                    w_ptr_upd    = 1'b1;
                    if (bus.dAck && r_beat >= 3'(MIN_BEATS)) begin
                        w_done_next = r_grant;
                    end else begin
                        w_err_next  = r_grant;
                    end
                end else begin
                    w_beat_next = r_beat + 3'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.dValid = (r_state == VALID);
    assign bus.busy   = (r_state == VALID);
    assign bus.grant  = r_grant;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.data   = r_data;
endmodule

// File: tb/tb_bus_protocol_arbiter.sv
// Directed self-checking bench for bus_protocol_arbiter (N_REQ=4, DW=8).
module tb_bus_protocol_arbiter;
    logic clk;
    logic reset_n;
    int unsigned n_tests;
    int unsigned n_fail;

    bus_protocol_arbiter_if #(.N_REQ(4), .DW(8)) bif ();

    bus_protocol_arbiter #(.N_REQ(4), .DW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer for requester w; ack_at = beat on which dAck is high (0 = never).
    task automatic do_xfer(input int unsigned w, input int unsigned ack_at,
                           input logic [7:0] d, input bit hold);
        logic [3:0] oh;
        logic [3:0] exp_done;
        logic [3:0] exp_err;
        oh       = 4'b0001 << w;
        exp_done = (ack_at >= 2 && ack_at <= 4) ? oh : 4'b0000;
        exp_err  = (ack_at >= 2 && ack_at <= 4) ? 4'b0000 : oh;
        step();
        for (int b = 1; b <= 4; b++) begin
            check($sformatf("r%0d_b%0d_dValid", w, b), {31'd0, bif.dValid}, 32'd1);
            check($sformatf("r%0d_b%0d_grant", w, b), {28'd0, bif.grant}, {28'd0, oh});
            check($sformatf("r%0d_b%0d_data", w, b), {24'd0, bif.data}, {24'd0, d});
            if (!hold) bif.req = '0;
            bif.dAck = (b == int'(ack_at));
            if (b == int'(ack_at) || b == 4) break;
            step();
        end
        step();
        bif.dAck = 1'b0;
        check($sformatf("r%0d_end_dValid", w), {31'd0, bif.dValid}, 32'd0);
        check($sformatf("r%0d_end_busy", w), {31'd0, bif.busy}, 32'd0);
        check($sformatf("r%0d_end_grant", w), {28'd0, bif.grant}, 32'd0);
        check($sformatf("r%0d_end_done", w), {28'd0, bif.done}, {28'd0, exp_done});
        check($sformatf("r%0d_end_err", w), {28'd0, bif.err}, {28'd0, exp_err});
        check($sformatf("r%0d_end_data", w), {24'd0, bif.data}, {24'd0, d});
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        bif.req      = '0;
        bif.req_data = '0;
        bif.dAck     = 1'b0;
        step();
        step();
        check("rst_dValid", {31'd0, bif.dValid}, 32'd0);
        check("rst_busy",   {31'd0, bif.busy},   32'd0);
        check("rst_grant",  {28'd0, bif.grant},  32'd0);
        check("rst_done",   {28'd0, bif.done},   32'd0);
        check("rst_err",    {28'd0, bif.err},    32'd0);
        check("rst_data",   {24'd0, bif.data},   32'd0);
        reset_n = 1'b1;
        step();

        // Requester 0, ack at beat 2.
        bif.req = 4'b0001;
        bif.req_data[0*8 +: 8] = 8'hA5;
        do_xfer(0, 2, 8'hA5, 1'b0);
        step();
        check("t1_done_pulse_off", {28'd0, bif.done}, 32'd0);

        // Requester 2, ack at beat 4; req_data changes mid-transfer are ignored.
        bif.req = 4'b0100;
        bif.req_data[2*8 +: 8] = 8'h3C;
        step();
        bif.req_data[2*8 +: 8] = 8'hFF;
        check("t2_b1_data", {24'd0, bif.data}, 32'h3C);
        bif.req = '0;
        step();
        step();
        check("t2_b3_data_held", {24'd0, bif.data}, 32'h3C);
        check("t2_b3_dValid", {31'd0, bif.dValid}, 32'd1);
        step();
        check("t2_b4_dValid", {31'd0, bif.dValid}, 32'd1);
        bif.dAck = 1'b1;
        step();
        bif.dAck = 1'b0;
        check("t2_end_dValid", {31'd0, bif.dValid}, 32'd0);
        check("t2_end_done", {28'd0, bif.done}, 32'b0100);
        check("t2_end_err",  {28'd0, bif.err},  32'd0);

        // Requester 1, no ack: timeout after 4 beats.
        bif.req = 4'b0010;
        bif.req_data[1*8 +: 8] = 8'h5E;
        do_xfer(1, 0, 8'h5E, 1'b0);

        // Pointer now at 2: with requesters 1 and 2 asking, 2 must win.
        bif.req = 4'b0110;
        bif.req_data[1*8 +: 8] = 8'h11;
        bif.req_data[2*8 +: 8] = 8'h22;
        do_xfer(2, 3, 8'h22, 1'b0);

        // Early ack on requester 3.
        bif.req = 4'b1000;
        bif.req_data[3*8 +: 8] = 8'hC3;
        do_xfer(3, 1, 8'hC3, 1'b0);

        // Fresh reset, then all four held: rotation 0,1,2,3,0 with one idle cycle between.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bif.req = 4'b1111;
        bif.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        do_xfer(0, 2, 8'h11, 1'b1);
        do_xfer(1, 2, 8'h22, 1'b1);
        do_xfer(2, 2, 8'h33, 1'b1);
        do_xfer(3, 2, 8'h44, 1'b1);
        do_xfer(0, 2, 8'h11, 1'b0);

        // dAck while idle is ignored.
        bif.dAck = 1'b1;
        step();
        step();
        bif.dAck = 1'b0;
        check("idle_ack_dValid", {31'd0, bif.dValid}, 32'd0);
        check("idle_ack_done",   {28'd0, bif.done},   32'd0);
        check("idle_ack_err",    {28'd0, bif.err},    32'd0);

        // Reset during beat 3 clears outputs immediately.
        bif.req = 4'b0001;
        bif.req_data[0*8 +: 8] = 8'h5A;
        step();
        bif.req = '0;
        step();
        step();
        check("mr_b3_dValid", {31'd0, bif.dValid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_dValid", {31'd0, bif.dValid}, 32'd0);
        check("mr_grant",  {28'd0, bif.grant},  32'd0);
        check("mr_data",   {24'd0, bif.data},   32'd0);
        check("mr_busy",   {31'd0, bif.busy},   32'd0);
        step();
        check("mr_done", {28'd0, bif.done}, 32'd0);
        check("mr_err",  {28'd0, bif.err},  32'd0);
        bif.req = 4'b0010;
        bif.req_data[1*8 +: 8] = 8'h77;
        reset_n = 1'b1;
        do_xfer(1, 2, 8'h77, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
